// File: rtl/reg_bank_sync_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_sync_pkg
// Shared definitions for the synchronous control/status register bank.
//   reg_type_e   : per-register behaviour code (2 bits per register in
//                  the REG_TYPES parameter of reg_bank_sync)
//   BYTE_W       : width of one byte-enable lane
//   reg_type_at  : extracts the type code of register i from a packed
//                  REG_TYPES vector
// -----------------------------------------------------------------------------
package reg_bank_sync_pkg;

  typedef enum logic [1:0] {
    REG_RW     = 2'd0,
    REG_RO     = 2'd1,
    REG_W1C    = 2'd2,
    REG_STROBE = 2'd3
  } reg_type_e;

  localparam int BYTE_W = 8;

  // Largest bank the helper can decode; REG_TYPES is zero-extended into it.
  localparam int MAX_REGS = 256;

  function automatic reg_type_e reg_type_at(input logic [2*MAX_REGS-1:0] types,
                                            input int idx);
    return reg_type_e'(types[2*idx +: 2]);
  endfunction

endpackage

// File: rtl/reg_bank_cell.sv
// -----------------------------------------------------------------------------
// reg_bank_cell
// One register of the bank. Behaviour is selected at elaboration by TYPE:
//   RW     : byte-enabled storage; with SHADOW=1 writes land in a shadow copy
//            and the active copy follows it only on commit.
//   RO     : stores nothing; reads return ro_value, active value is 0.
//   W1C    : status bits set by hw_set, cleared by writing 1 (set wins).
//   STROBE : bits written 1 are high on active_value for one cycle.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   wr_en          : decoded write to this register (bus already qualified)
//   wr_data        : write data
//   wr_mask        : per-bit write mask expanded from the byte enables
//   commit         : frame-boundary pulse, shadow -> active
//   ro_value       : live value for RO registers
//   hw_set         : per-bit set pulses for W1C registers
//   rd_value       : value returned on a bus read
//   active_value   : value driven onto values_out
// -----------------------------------------------------------------------------
module reg_bank_cell
  import reg_bank_sync_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 16,
  parameter reg_type_e             TYPE        = REG_RW,
  parameter bit                    SHADOW      = 1'b0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  input  logic                  commit,
  input  logic [DATA_WIDTH-1:0] ro_value,
  input  logic [DATA_WIDTH-1:0] hw_set,
  output logic [DATA_WIDTH-1:0] rd_value,
  output logic [DATA_WIDTH-1:0] active_value
);

  // Only RW and W1C registers have a meaningful reset value; strobes and
  // RO cells always come out of reset at zero.
  localparam logic [DATA_WIDTH-1:0] INIT_VALUE =
    (TYPE == REG_RW || TYPE == REG_W1C) ? RESET_VALUE : '0;
  localparam bit IS_SHADOWED = SHADOW && (TYPE == REG_RW);

  // state_q is the shadow for RW, the status for W1C, the pulse for STROBE.
  logic [DATA_WIDTH-1:0] state_d, state_q;
  logic [DATA_WIDTH-1:0] active_d, active_q;
  logic [DATA_WIDTH-1:0] wr_ones;

  always_comb begin
    wr_ones = wr_en ? (wr_data & wr_mask) : '0;
    state_d = state_q;
    case (TYPE)
      REG_RW:     if (wr_en) state_d = (state_q & ~wr_mask) | (wr_data & wr_mask);
      REG_W1C:    state_d = (state_q & ~wr_ones) | hw_set;
      REG_STROBE: state_d = wr_ones;
      default:    state_d = '0;
    endcase

    // Using state_d (not state_q) lets a write in the commit cycle reach
    // the active copy at the same edge.
    if (IS_SHADOWED) begin
      active_d = commit ? state_d : active_q;
    end else begin
      active_d = state_d;
    end

    case (TYPE)
      REG_RW:  rd_value = state_q;
      REG_W1C: rd_value = state_q;
      REG_RO:  rd_value = ro_value;
      default: rd_value = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= INIT_VALUE;
      active_q <= INIT_VALUE;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
    end
  end

  assign active_value = active_q;

endmodule

// File: rtl/reg_bank_sync.sv
// -----------------------------------------------------------------------------
// reg_bank_sync
// Synchronous control/status register bank with per-register types,
// byte enables, double-buffered RW registers and W1C status with irq.
// Ports:
//   clk, reset   : system clock, asynchronous active-high reset
//   en, rd, wr   : bus access; rd&wr together is a write only
//   be           : byte enables for writes (DATA_WIDTH/8)
//   addr         : register address; addr >= NUM_REGS reads 0, writes dropped
//   data_in      : write data
//   data_out     : registered read data (one-cycle latency)
//   data_valid   : one-cycle flag accompanying each read result
//   commit       : frame-boundary pulse copying shadows to active copies
//   values_in    : live values for RO registers (slice per register)
//   hw_set       : per-bit set pulses for W1C registers
//   values_out   : active value of every register (RO slices are 0)
//   irq          : registered OR of all W1C status bits
// -----------------------------------------------------------------------------
module reg_bank_sync
  import reg_bank_sync_pkg::*;
#(
  parameter int                               ADDR_WIDTH   = 4,
  parameter int                               DATA_WIDTH   = 16,
  parameter int                               NUM_REGS     = 16,
  parameter logic [2*NUM_REGS-1:0]            REG_TYPES    = '0,
  parameter logic [NUM_REGS-1:0]              SHADOW_MASK  = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RESET_VALUES = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           rd,
  input  logic                           wr,
  input  logic [DATA_WIDTH/8-1:0]        be,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [DATA_WIDTH-1:0]          data_in,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           data_valid,
  input  logic                           commit,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] values_in,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
  output logic [NUM_REGS*DATA_WIDTH-1:0] values_out,
  output logic                           irq
);

  localparam int NUM_BYTES = DATA_WIDTH / BYTE_W;
  localparam logic [2*MAX_REGS-1:0] TYPES_EXT = (2*MAX_REGS)'(REG_TYPES);

  logic                  wr_access, rd_access;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic [NUM_REGS-1:0]   wr_sel;
  logic [NUM_REGS-1:0]   w1c_any;
  logic [DATA_WIDTH-1:0] rd_vals     [NUM_REGS];
  logic [DATA_WIDTH-1:0] active_vals [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_mux;

  logic [DATA_WIDTH-1:0] data_out_d, data_out_q;
  logic                  data_valid_d, data_valid_q;
  logic                  irq_d, irq_q;

  // Address decode: an address matching no register selects nothing, so
  // out-of-range writes are dropped and out-of-range reads return 0.
  always_comb begin
    wr_access = en & wr;
    rd_access = en & rd & ~wr;

    for (int b = 0; b < NUM_BYTES; b++) begin
      wr_mask[b*BYTE_W +: BYTE_W] = {BYTE_W{be[b]}};
    end

    wr_sel = '0;
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_WIDTH'(i)) begin
        wr_sel[i] = wr_access;
        rd_mux    = rd_vals[i];
      end
    end

    data_out_d   = rd_access ? rd_mux : data_out_q;
    data_valid_d = rd_access;
    irq_d        = |w1c_any;
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam reg_type_e CELL_TYPE = reg_type_at(TYPES_EXT, i);

    reg_bank_cell #(
      .DATA_WIDTH  (DATA_WIDTH),
      .TYPE        (CELL_TYPE),
      .SHADOW      (SHADOW_MASK[i]),
      .RESET_VALUE (RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH])
    ) u_cell (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_sel[i]),
      .wr_data      (data_in),
      .wr_mask      (wr_mask),
      .commit       (commit),
      .ro_value     (values_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .hw_set       (hw_set[i*DATA_WIDTH +: DATA_WIDTH]),
      .rd_value     (rd_vals[i]),
      .active_value (active_vals[i])
    );

    assign values_out[i*DATA_WIDTH +: DATA_WIDTH] = active_vals[i];
    assign w1c_any[i] = (CELL_TYPE == REG_W1C) ? |active_vals[i] : 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      irq_q        <= irq_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_reg_bank_sync.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_sync
// Bench for reg_bank_sync with a 12-register bank:
//   reg0 RW reset FFFF, reg2 RW reset A5A5, reg3 RW shadowed reset 1111,
//   reg5 W1C, reg6 STROBE, reg7 RO (values_in = 7777), others RW reset 0.
// Read results are queued when the read is driven and popped by a monitor
// whenever data_valid is seen.
// -----------------------------------------------------------------------------
module tb_reg_bank_sync;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int NR = 12;
  localparam logic [2*NR-1:0]  TYPES  = 24'h007800;
  localparam logic [NR-1:0]    SHADOW = 12'h008;
  localparam logic [NR*DW-1:0] RSTV   = {128'h0, 16'h1111, 16'hA5A5, 16'h0000, 16'hFFFF};

  logic           clk = 1'b0;
  logic           reset;
  logic           en, rd, wr, commit;
  logic [1:0]     be;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  data_in;
  logic [DW-1:0]  data_out;
  logic           data_valid;
  logic [NR*DW-1:0] values_in, hw_set, values_out;
  logic           irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  reg_bank_sync #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .NUM_REGS     (NR),
    .REG_TYPES    (TYPES),
    .SHADOW_MASK  (SHADOW),
    .RESET_VALUES (RSTV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .rd         (rd),
    .wr         (wr),
    .be         (be),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .commit     (commit),
    .values_in  (values_in),
    .hw_set     (hw_set),
    .values_out (values_out),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] vo(input int i);
    return values_out[i*DW +: DW];
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read-result scoreboard.
  always @(posedge clk) begin
    #1;
    if (data_valid === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: data_out %h with no read pending", data_out);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          n_fail++;
          $display("FAIL read_data: got %h expected %h", data_out, e);
        end
      end
    end
  end

  // One bus cycle: drive at negedge, hold across the edge, release after it.
  task automatic op(input bit r, input bit w, input logic [AW-1:0] a, input logic [1:0] b,
                    input logic [DW-1:0] d, input bit cm, input logic [DW-1:0] hs5,
                    input logic [DW-1:0] exp_rd);
    @(negedge clk);
    en = r | w; rd = r; wr = w; addr = a; be = b; data_in = d; commit = cm;
    hw_set = '0;
    hw_set[5*DW +: DW] = hs5;
    if (r && !w) exp_q.push_back(exp_rd);
    @(posedge clk);
    #1;
    en = 1'b0; rd = 1'b0; wr = 1'b0; commit = 1'b0; hw_set = '0;
  endtask

  task automatic idle();
    op(1'b0, 1'b0, '0, 2'b00, '0, 1'b0, '0, '0);
  endtask

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] a;
    logic [1:0]    b;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_rd;
    int            chk_reg;
    logic [DW-1:0] exp_vo;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en = 0; rd = 0; wr = 0; commit = 0; be = '0; addr = '0; data_in = '0;
    hw_set = '0; values_in = '0;
    values_in[7*DW +: DW] = 16'h7777;

    vecs[0]  = '{1'b1, 4'd0,  2'b01, 16'h1234, 16'h0000, 0, 16'hFF34};
    vecs[1]  = '{1'b0, 4'd0,  2'b00, 16'h0000, 16'hFF34, 0, 16'hFF34};
    vecs[2]  = '{1'b1, 4'd1,  2'b10, 16'hABCD, 16'h0000, 1, 16'hAB00};
    vecs[3]  = '{1'b1, 4'd1,  2'b11, 16'h5A5A, 16'h0000, 1, 16'h5A5A};
    vecs[4]  = '{1'b0, 4'd1,  2'b00, 16'h0000, 16'h5A5A, 1, 16'h5A5A};
    vecs[5]  = '{1'b1, 4'd3,  2'b11, 16'h00C8, 16'h0000, 3, 16'h1111};
    vecs[6]  = '{1'b0, 4'd3,  2'b00, 16'h0000, 16'h00C8, 3, 16'h1111};
    vecs[7]  = '{1'b0, 4'd2,  2'b00, 16'h0000, 16'hA5A5, 2, 16'hA5A5};
    vecs[8]  = '{1'b0, 4'd6,  2'b00, 16'h0000, 16'h0000, 6, 16'h0000};
    vecs[9]  = '{1'b0, 4'd12, 2'b00, 16'h0000, 16'h0000, 0, 16'hFF34};
    vecs[10] = '{1'b1, 4'd13, 2'b11, 16'hFFFF, 16'h0000, 1, 16'h5A5A};
    vecs[11] = '{1'b1, 4'd7,  2'b11, 16'hBEEF, 16'h0000, 7, 16'h0000};
    vecs[12] = '{1'b0, 4'd7,  2'b00, 16'h0000, 16'h7777, 7, 16'h0000};
    vecs[13] = '{1'b0, 4'd15, 2'b00, 16'h0000, 16'h0000, 2, 16'hA5A5};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_reg2", vo(2), 16'hA5A5);
    chk("rst_reg0", vo(0), 16'hFFFF);
    chk("rst_reg3", vo(3), 16'h1111);
    chk("rst_data_out", data_out, 16'h0000);
    chk("rst_valid", {15'd0, data_valid}, 16'h0000);
    chk("rst_irq", {15'd0, irq}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven single accesses.
    for (int i = 0; i < 14; i++) begin
      op(!vecs[i].is_wr, vecs[i].is_wr, vecs[i].a, vecs[i].b, vecs[i].d, 1'b0, '0, vecs[i].exp_rd);
      chk($sformatf("vec%0d_reg%0d", i, vecs[i].chk_reg), vo(vecs[i].chk_reg), vecs[i].exp_vo);
    end

    // Back-to-back reads, then data_valid must fall.
    op(1'b1, 1'b0, 4'd0, 2'b00, '0, 1'b0, '0, 16'hFF34);
    op(1'b1, 1'b0, 4'd2, 2'b00, '0, 1'b0, '0, 16'hA5A5);
    op(1'b1, 1'b0, 4'd1, 2'b00, '0, 1'b0, '0, 16'h5A5A);
    idle();
    chk("b2b_valid_drop", {15'd0, data_valid}, 16'h0000);
    chk("b2b_queue_empty", 16'(exp_q.size()), 16'h0000);

    // Read+write together behaves as a write with no read result.
    op(1'b1, 1'b1, 4'd1, 2'b11, 16'h0F0F, 1'b0, '0, '0);
    chk("rdwr_write", vo(1), 16'h0F0F);
    idle();
    chk("rdwr_no_valid", {15'd0, data_valid}, 16'h0000);

    // Commit: shadow reaches active; write in the commit cycle wins.
    op(1'b0, 1'b0, '0, 2'b00, '0, 1'b1, '0, '0);
    chk("commit_reg3", vo(3), 16'h00C8);
    op(1'b0, 1'b1, 4'd3, 2'b11, 16'h0001, 1'b1, '0, '0);
    chk("commit_wr_reg3", vo(3), 16'h0001);
    op(1'b1, 1'b0, 4'd3, 2'b00, '0, 1'b0, '0, 16'h0001);

    // W1C status with irq.
    op(1'b0, 1'b0, '0, 2'b00, '0, 1'b0, 16'h0010, '0);
    chk("w1c_set", vo(5), 16'h0010);
    chk("irq_lag", {15'd0, irq}, 16'h0000);
    idle();
    chk("irq_rise", {15'd0, irq}, 16'h0001);
    op(1'b0, 1'b1, 4'd5, 2'b11, 16'h0010, 1'b0, 16'h0010, '0);
    chk("w1c_set_wins", vo(5), 16'h0010);
    op(1'b1, 1'b0, 4'd5, 2'b00, '0, 1'b0, '0, 16'h0010);
    op(1'b0, 1'b1, 4'd5, 2'b11, 16'h0010, 1'b0, '0, '0);
    chk("w1c_clear", vo(5), 16'h0000);
    chk("irq_hold", {15'd0, irq}, 16'h0001);
    idle();
    chk("irq_fall", {15'd0, irq}, 16'h0000);

    // Strobe pulses for exactly one cycle.
    op(1'b0, 1'b1, 4'd6, 2'b11, 16'h0003, 1'b0, '0, '0);
    chk("strobe_hi", vo(6), 16'h0003);
    idle();
    chk("strobe_lo", vo(6), 16'h0000);
    op(1'b1, 1'b0, 4'd6, 2'b00, '0, 1'b0, '0, 16'h0000);

    // Reset during a read: no data_valid, registers reload.
    @(negedge clk);
    en = 1'b1; rd = 1'b1; addr = 4'd0; reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_valid", {15'd0, data_valid}, 16'h0000);
    chk("rst_mid_reg0", vo(0), 16'hFFFF);
    chk("rst_mid_reg3", vo(3), 16'h1111);
    @(negedge clk);
    en = 1'b0; rd = 1'b0; reset = 1'b0;
    idle();
    chk("final_queue_empty", 16'(exp_q.size()), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
